// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add multiply and restoring divide,
// with valid/ready handshakes on request and result sides and one operation in flight.
module seq_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         dz
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_LESS = 4'd1;
  localparam logic [3:0] OP_EQ   = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_MOD  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  result_q, result_d;
  logic          dz_q, dz_d;

  logic [N-1:0]  alu_res;
  logic          alu_dz;
  logic          iterative;
  logic [N-1:0]  mul_acc_nx;
  logic [N:0]    rem_sh;
  logic [N:0]    rem_diff;
  logic          q_bit;
  logic [N-1:0]  rem_nx;
  logic [N-1:0]  quo_nx;

  // Results of the ops that finish at the accept edge, straight from the live inputs.
  always_comb begin
    alu_res   = '0;
    alu_dz    = 1'b0;
    iterative = 1'b0;
    case (opcode)
      OP_ADD:  alu_res = op_a + op_b;
      OP_LESS: alu_res = {{(N-1){1'b0}}, (op_a < op_b)};
      OP_EQ:   alu_res = {{(N-1){1'b0}}, (op_a == op_b)};
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_NOT:  alu_res = {{(N-1){1'b0}}, (op_a == '0)};
      OP_MUL:  iterative = 1'b1;
      OP_DIV: begin
        alu_res   = '1;
        alu_dz    = (op_b == '0);
        iterative = (op_b != '0);
      end
      OP_MOD: begin
        alu_res   = op_a;
        alu_dz    = (op_b == '0);
        iterative = (op_b != '0);
      end
      default: alu_res = '0;
    endcase
  end

  // One iteration step. For DIV/MOD, a_q holds the dividend shifting out of the top
  // while quotient bits shift into the bottom; rem_sh is the N+1-bit partial remainder.
  always_comb begin
    mul_acc_nx = acc_q + (b_q[0] ? a_q : '0);
    rem_sh     = {rem_q, a_q[N-1]};
    rem_diff   = rem_sh - {1'b0, b_q};
    q_bit      = ~rem_diff[N];
    rem_nx     = q_bit ? rem_diff[N-1:0] : rem_sh[N-1:0];
    quo_nx     = {a_q[N-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = iterative ? S_CALC : S_DONE;
      S_CALC: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = opcode;
          a_d   = op_a;
          b_d   = op_b;
          acc_d = '0;
          rem_d = '0;
          cnt_d = CW'(N - 1);
          dz_d  = alu_dz;
          if (!iterative) result_d = alu_res;
        end
      end
      S_CALC: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_d = mul_acc_nx;
          a_d   = {a_q[N-2:0], 1'b0};
          b_d   = {1'b0, b_q[N-1:1]};
          if (cnt_q == '0) result_d = mul_acc_nx;
        end else begin
          rem_d = rem_nx;
          a_d   = quo_nx;
          if (cnt_q == '0) result_d = (op_q == OP_DIV) ? quo_nx : rem_nx;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = result_q;
    dz        = dz_q;
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed checks of seq_alu at N=8 against an arithmetic reference model,
// with a queue-based scoreboard popped by an independent output monitor.
module tb_seq_alu;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = '0;
  logic [N-1:0] op_a = '0;
  logic [N-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result;
  logic         dz;

  seq_alu #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic         dz;
    int           lat;
    int           acc_edge;
    logic [3:0]   op;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  bit   rnd_bp = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  task automatic model(input int op, input int a, input int b,
                       output logic [N-1:0] r, output logic z, output int lat);
    int m;
    m   = 1 << N;
    z   = 1'b0;
    lat = 1;
    case (op)
      0: r = N'((a + b) % m);
      1: r = N'((a < b) ? 1 : 0);
      2: r = N'((a == b) ? 1 : 0);
      3: r = N'(a | b);
      4: r = N'(a & b);
      5: r = N'((a == 0) ? 1 : 0);
      6: begin r = N'((a * b) % m); lat = N + 1; end
      7: if (b == 0) begin r = N'(m - 1); z = 1'b1; end
         else begin r = N'(a / b); lat = N + 1; end
      8: if (b == 0) begin r = N'(a); z = 1'b1; end
         else begin r = N'(a % b); lat = N + 1; end
      default: r = '0;
    endcase
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 100) begin
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    model(int'(op), int'(a), int'(b), e.res, e.dz, e.lat);
    e.acc_edge = edge_cnt + 1;
    e.op       = op;
    sb.push_back(e);
    $display("[TB] issue op=%0d a=%0d b=%0d -> expect %0d dz=%0d lat=%0d", op, a, b, e.res, e.dz, e.lat);
    opcode   = op;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode   = 4'($urandom);
    op_a     = N'($urandom);
    op_b     = N'($urandom);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compare the front of the scoreboard every cycle out_valid is high,
  // check latency on the first cycle, pop on the handshake edge.
  bit seen = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid: got result=%0d dz=%0d expected no output", result, dz);
        end else begin
          if (!seen) begin
            check("latency", 32'(edge_cnt - sb[0].acc_edge + 1), 32'(sb[0].lat));
            $display("[TB] result op=%0d got %0d dz=%0d", sb[0].op, result, dz);
          end
          seen = 1'b1;
          check("result", {24'd0, result}, {24'd0, sb[0].res});
          check("dz", {31'd0, dz}, {31'd0, sb[0].dz});
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  typedef struct { logic [3:0] op; logic [N-1:0] a; logic [N-1:0] b; } stim_t;
  stim_t dir_tbl[$];

  initial begin
    int n;
    dir_tbl = '{
      '{4'd1, 8'd3, 8'd5},     '{4'd2, 8'd7, 8'd7},     '{4'd3, 8'hF0, 8'h0F},
      '{4'd4, 8'hF0, 8'h3C},   '{4'd5, 8'd0, 8'd0},     '{4'd5, 8'd5, 8'd0},
      '{4'd12, 8'd1, 8'd2},    '{4'd6, 8'd13, 8'd11},   '{4'd6, 8'd20, 8'd20},
      '{4'd7, 8'd200, 8'd7},   '{4'd8, 8'd200, 8'd7},   '{4'd7, 8'd255, 8'd1},
      '{4'd8, 8'd5, 8'd9},     '{4'd7, 8'd9, 8'd0},     '{4'd8, 8'd9, 8'd0}
    };

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_dz", {31'd0, dz}, 32'd0);

    out_ready = 1'b1;
    issue(4'd0, 8'd200, 8'd100);
    tick(1);
    check("add_in_ready_T2", {31'd0, in_ready}, 32'd1);

    foreach (dir_tbl[i]) issue(dir_tbl[i].op, dir_tbl[i].a, dir_tbl[i].b);

    // Backpressure: result held while out_ready=0; requests meanwhile are ignored.
    tick(12);
    out_ready = 1'b0;
    issue(4'd6, 8'd7, 8'd9);
    for (int i = 0; i < N + 5; i++) begin
      in_valid = 1'b1;
      opcode   = 4'd0;
      op_a     = 8'd1;
      op_b     = 8'd1;
      tick(1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(2);

    // Abort an in-flight divide with a one-cycle reset.
    issue(4'd7, 8'd100, 8'd3);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sb.delete();
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    tick(N + 3);
    check("abort_no_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset wins over a simultaneous accept.
    in_valid = 1'b1;
    opcode   = 4'd0;
    op_a     = 8'd50;
    op_b     = 8'd60;
    rst      = 1'b1;
    tick(1);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick(1);
    check("rst_priority_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_priority_in_ready", {31'd0, in_ready}, 32'd1);

    issue(4'd0, 8'd1, 8'd1);

    // Random phase with random backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [3:0]   op;
      logic [N-1:0] b;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(6, 8));
      b = N'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      issue(op, N'($urandom), b);
    end
    rnd_bp    = 1'b0;
    out_ready = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
